// File: rtl/vga_fb_scheduler_pkg.sv
// Shared timing constants, frame buffer geometry and types for the
// display-side frame buffer scheduler.
//   fb_line_base() : row index -> first address of that row, built from
//                    shifts and adds of the constant FB_W (no multiplier).
package vga_pkg;

    localparam int H_VIS   = 640;
    localparam int V_VIS   = 480;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int FB_W    = 320;
    localparam int FB_H    = 240;
    localparam int SCALE   = 2;
    localparam int ADDR_W  = 17;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic {
        DISPLAY = 1'b0,
        PENDING = 1'b1
    } bank_state_e;

    // Constant multiply by FB_W expressed as a sum of shifted copies of row.
    function automatic logic [ADDR_W-1:0] fb_line_base(input logic [9:0] row);
        logic [ADDR_W-1:0] acc;
        logic [31:0]       w;
        acc = '0;
        w   = 32'(FB_W);
        for (int i = 0; i < ADDR_W; i++) begin
            if (w[i]) begin
                acc = acc + (ADDR_W'(row) << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_fb_scheduler_sync_delay_line.sv
// Fixed-depth shift register for a small bundle of timing signals.
//   clk, reset : pixel clock, asynchronous active-high reset
//   din        : bundle entering the line
//   dout       : bundle delayed by DEPTH clocks; every stage resets to RESET_VAL
module sync_delay_line #(
    parameter int                 DEPTH     = 2,
    parameter int                 WIDTH     = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain; reset loads every stage with the idle value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VAL;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_fb_scheduler.sv
// Display-side read scheduler for a double-buffered QVGA RGB565 frame buffer.
// Issues 2x-upscaled read addresses from the VGA timing, maps returned pixels
// to RGB444 aligned with delayed syncs, and swaps bank ownership in vertical
// blank once the writer has completed a frame.
//   inputs : clk, reset, h_sync, v_sync, DE, x_pixel, y_pixel,
//            wr_frame_done, rd_data
//   outputs: rd_en, rd_addr, rd_bank, wr_bank, swap_ack, overrun,
//            vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b (all registered)
module vga_fb_scheduler
    import vga_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic              DE,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic              wr_frame_done,
    input  logic [15:0]       rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              wr_bank,
    output logic              swap_ack,
    output logic              overrun,
    output logic              vga_h_sync,
    output logic              vga_v_sync,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b
);

    localparam int PIPE     = 2 + RD_LAT;
    localparam int SCALE_SH = $clog2(SCALE);

    logic [9:0]        row_s;
    logic [9:0]        col_s;
    logic [ADDR_W-1:0] addr_s;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;

    // Downscale the screen coordinate and form the linear buffer address.
    always_comb begin
        row_s  = y_pixel >> SCALE_SH;
        col_s  = x_pixel >> SCALE_SH;
        addr_s = fb_line_base(row_s) + ADDR_W'(col_s);
    end

    // Read request register; the address freezes outside the visible area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en_r   <= 1'b0;
            rd_addr_r <= '0;
        end else begin
            rd_en_r <= DE;
            if (DE) begin
                rd_addr_r <= addr_s;
            end else begin
                rd_addr_r <= rd_addr_r;
            end
        end
    end

    bank_state_e state_r;
    bank_state_e state_s;
    logic        at_swap_s;
    logic        swap_s;
    logic        overrun_set_s;
    logic        rd_bank_r;
    logic        wr_bank_r;
    logic        swap_ack_r;
    logic        overrun_r;
    logic        frame_valid_r;

    assign at_swap_s = (x_pixel == 10'd0) && (y_pixel == 10'(V_VIS));

    // Bank FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= DISPLAY;
        end else begin
            state_r <= state_s;
        end
    end

    // Bank FSM next state; a done pulse on the swap cycle is consumed by the
    // swap it coincides with and only flags overrun.
    always_comb begin
        state_s       = state_r;
        swap_s        = 1'b0;
        overrun_set_s = 1'b0;
        case (state_r)
            DISPLAY: begin
                if (wr_frame_done) begin
                    state_s = PENDING;
                end else begin
                    state_s = DISPLAY;
                end
            end
            PENDING: begin
                overrun_set_s = wr_frame_done;
                if (at_swap_s) begin
                    swap_s  = 1'b1;
                    state_s = DISPLAY;
                end else begin
                    state_s = PENDING;
                end
            end
            default: begin
                state_s = DISPLAY;
            end
        endcase
    end

    // Bank ownership, swap strobe, sticky overrun and first-frame flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_bank_r     <= 1'b0;
            wr_bank_r     <= 1'b1;
            swap_ack_r    <= 1'b0;
            overrun_r     <= 1'b0;
            frame_valid_r <= 1'b0;
        end else begin
            swap_ack_r <= swap_s;
            overrun_r  <= overrun_r | overrun_set_s;
            if (swap_s) begin
                rd_bank_r     <= ~rd_bank_r;
                wr_bank_r     <= ~wr_bank_r;
                frame_valid_r <= 1'b1;
            end else begin
                rd_bank_r     <= rd_bank_r;
                wr_bank_r     <= wr_bank_r;
                frame_valid_r <= frame_valid_r;
            end
        end
    end

    // The delay line covers PIPE-1 clocks so its DE lines up with rd_data;
    // the output register below supplies the last stage for syncs and colour.
    logic [2:0] dly_s;

    sync_delay_line #(
        .DEPTH     (PIPE - 1),
        .WIDTH     (3),
        .RESET_VAL (3'b110)
    ) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .din   ({h_sync, v_sync, DE}),
        .dout  (dly_s)
    );

    rgb565_t    px_s;
    logic       vga_h_sync_r;
    logic       vga_v_sync_r;
    logic [3:0] vga_r_r;
    logic [3:0] vga_g_r;
    logic [3:0] vga_b_r;
    logic       unused_px_bits_s;

    assign px_s             = rgb565_t'(rd_data);
    assign unused_px_bits_s = ^{px_s.r[0], px_s.g[1:0], px_s.b[0]};

    // Output stage: delayed syncs and RGB444, black until a frame is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_h_sync_r <= 1'b1;
            vga_v_sync_r <= 1'b1;
            vga_r_r      <= 4'h0;
            vga_g_r      <= 4'h0;
            vga_b_r      <= 4'h0;
        end else begin
            vga_h_sync_r <= dly_s[2];
            vga_v_sync_r <= dly_s[1];
            if (dly_s[0] && frame_valid_r) begin
                vga_r_r <= px_s.r[4:1];
                vga_g_r <= px_s.g[5:2];
                vga_b_r <= px_s.b[4:1];
            end else begin
                vga_r_r <= 4'h0;
                vga_g_r <= 4'h0;
                vga_b_r <= 4'h0;
            end
        end
    end

    assign rd_en      = rd_en_r;
    assign rd_addr    = rd_addr_r;
    assign rd_bank    = rd_bank_r;
    assign wr_bank    = wr_bank_r;
    assign swap_ack   = swap_ack_r;
    assign overrun    = overrun_r;
    assign vga_h_sync = vga_h_sync_r;
    assign vga_v_sync = vga_v_sync_r;
    assign vga_r      = vga_r_r;
    assign vga_g      = vga_g_r;
    assign vga_b      = vga_b_r;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler with a one-clock frame buffer model and
// a queue of expected {vga_h_sync, vga_v_sync, r, g, b} per driven pixel.
module tb_vga_fb_scheduler;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_sync, v_sync, DE, wr_frame_done;
    logic [9:0]  x_pixel, y_pixel;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_en, rd_bank, wr_bank, swap_ack, overrun;
    logic [16:0] rd_addr;
    logic        vga_h_sync, vga_v_sync;
    logic [3:0]  vga_r, vga_g, vga_b;

    always #20 clk = ~clk;

    vga_fb_scheduler #(.RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
        .x_pixel(x_pixel), .y_pixel(y_pixel), .wr_frame_done(wr_frame_done),
        .rd_data(rd_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .wr_bank(wr_bank), .swap_ack(swap_ack), .overrun(overrun),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    // Pixel content stored in the buffer; address 641 holds pure red.
    function automatic logic [15:0] pix(input logic [16:0] a);
        if (a == 17'd641) return 16'hF800;
        return a[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [11:0] rgb_of(input logic [15:0] d);
        return {d[15:12], d[10:7], d[4:1]};
    endfunction

    // Frame buffer with one clock of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= pix(rd_addr);
    end

    localparam logic [13:0] RST_E = 14'b11_0000_0000_0000;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_q [$];
    logic        fv_m;
    logic        exp_en;
    logic [16:0] exp_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        logic [13:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("pipe_out", {18'd0, vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b}, {18'd0, e});
        end
        check("rd_en", {31'd0, rd_en}, {31'd0, exp_en});
        check("rd_addr", {15'd0, rd_addr}, {15'd0, exp_addr});
    endtask

    task automatic drive(input logic h, input logic v, input logic de,
                         input int x, input int y, input logic done);
        logic [16:0] a;
        h_sync        = h;
        v_sync        = v;
        DE            = de;
        x_pixel       = 10'(x);
        y_pixel       = 10'(y);
        wr_frame_done = done;
        a = 17'((y / 2) * 320 + x / 2);
        exp_q.push_back({h, v, (de && fv_m) ? rgb_of(pix(a)) : 12'h000});
        exp_en = de;
        if (de) exp_addr = a;
        tick();
    endtask

    task automatic px(input int x, input int y, input logic de, input logic done);
        drive(1'b1, 1'b1, de, x, y, done);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
        check({tag, "_rd_addr"}, {15'd0, rd_addr}, 32'd0);
        check({tag, "_banks"}, {30'd0, rd_bank, wr_bank}, 32'd1);
        check({tag, "_swap_ack"}, {31'd0, swap_ack}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        check({tag, "_syncs"}, {30'd0, vga_h_sync, vga_v_sync}, 32'd3);
        check({tag, "_rgb"}, {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_E);
        exp_q.push_back(RST_E);
        fv_m     = 1'b0;
        exp_en   = 1'b0;
        exp_addr = 17'd0;
    endtask

    task automatic chk_bank(input string tag, input logic rb, input logic ack, input logic ovr);
        check({tag, "_rd_bank"}, {31'd0, rd_bank}, {31'd0, rb});
        check({tag, "_wr_bank"}, {31'd0, wr_bank}, {31'd0, ~rb});
        check({tag, "_swap_ack"}, {31'd0, swap_ack}, {31'd0, ack});
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, ovr});
    endtask

    initial begin
        // Reset with DE active on a pixel.
        reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1; DE = 1'b1;
        x_pixel = 10'd5; y_pixel = 10'd5; wr_frame_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        release_reset();

        // Addressing, display still black before the first swap.
        px(0, 0, 1'b1, 1'b0);
        px(3, 5, 1'b1, 1'b0);
        px(639, 479, 1'b1, 1'b0);
        px(100, 100, 1'b0, 1'b0);
        px(200, 100, 1'b0, 1'b0);

        // Swap sequencing.
        px(10, 100, 1'b1, 1'b1);
        chk_bank("after_done", 1'b0, 1'b0, 1'b0);
        px(20, 300, 1'b1, 1'b0);
        px(5, 480, 1'b0, 1'b0);
        chk_bank("near_swap", 1'b0, 1'b0, 1'b0);
        px(0, 480, 1'b0, 1'b0);
        fv_m = 1'b1;
        chk_bank("swap1", 1'b1, 1'b1, 1'b0);
        px(1, 480, 1'b0, 1'b0);
        chk_bank("swap1_end", 1'b1, 1'b0, 1'b0);
        px(0, 480, 1'b0, 1'b0);
        chk_bank("no_pulse", 1'b1, 1'b0, 1'b0);

        // Latency: red pixel emerges three clocks after it is presented.
        px(3, 5, 1'b1, 1'b0);
        px(4, 5, 1'b1, 1'b0);
        px(5, 5, 1'b1, 1'b0);
        check("red_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'hF00);
        drive(1'b0, 1'b1, 1'b0, 650, 5, 1'b0);
        check("hs_d1", {31'd0, vga_h_sync}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 651, 5, 1'b0);
        check("hs_d2", {31'd0, vga_h_sync}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 652, 5, 1'b0);
        check("hs_d3", {31'd0, vga_h_sync}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 700, 490, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 701, 490, 1'b0);
        for (int i = 0; i < 20; i++) begin
            px(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)), 1'b1, 1'b0);
        end

        // Overrun: two done pulses in one frame, exactly one swap.
        px(650, 5, 1'b0, 1'b0);
        px(7, 10, 1'b1, 1'b1);
        chk_bank("ovr_a1", 1'b1, 1'b0, 1'b0);
        px(7, 20, 1'b1, 1'b1);
        chk_bank("ovr_a2", 1'b1, 1'b0, 1'b1);
        px(5, 480, 1'b0, 1'b0);
        px(0, 480, 1'b0, 1'b0);
        chk_bank("ovr_a_swap", 1'b0, 1'b1, 1'b1);
        px(1, 480, 1'b0, 1'b0);
        px(0, 480, 1'b0, 1'b0);
        chk_bank("ovr_a_after", 1'b0, 1'b0, 1'b1);

        // Reset mid-frame with a swap pending.
        px(3, 150, 1'b1, 1'b1);
        px(3, 200, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk);
        #1;
        check_reset_vals("mid_reset_hold");
        release_reset();
        px(4, 200, 1'b1, 1'b0);
        px(5, 480, 1'b0, 1'b0);
        px(0, 480, 1'b0, 1'b0);
        chk_bank("post_reset", 1'b0, 1'b0, 1'b0);
        px(3, 5, 1'b1, 1'b0);
        px(9, 7, 1'b1, 1'b0);
        px(11, 9, 1'b1, 1'b0);

        // Overrun: done pulse coincides with the swap point.
        px(3, 50, 1'b1, 1'b1);
        chk_bank("ovr_b1", 1'b0, 1'b0, 1'b0);
        px(5, 480, 1'b0, 1'b0);
        px(0, 480, 1'b0, 1'b1);
        fv_m = 1'b1;
        chk_bank("ovr_b_swap", 1'b1, 1'b1, 1'b1);
        px(1, 480, 1'b0, 1'b0);
        px(0, 480, 1'b0, 1'b0);
        chk_bank("ovr_b_after", 1'b1, 1'b0, 1'b1);
        px(3, 5, 1'b1, 1'b0);
        px(8, 9, 1'b1, 1'b0);
        px(638, 478, 1'b1, 1'b0);
        px(650, 478, 1'b0, 1'b0);
        px(651, 478, 1'b0, 1'b0);
        px(652, 478, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
